// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: drives the per-stage en/clear controls,
// tracks multi-cycle EX ops and keeps saturating stall/flush counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_rs1/id_rs2       ID-stage source registers (+ *_used qualifiers)
//   ex_rd, ex_mem_read  EX-stage destination register, EX is a load
//   ex_branch_taken     EX redirects the PC
//   ex_mc_start         first EX cycle of a multi-cycle op
//   mc_done             multi-cycle result valid pulse
//   dmem_stall          data memory not ready
//   perf_clr            clear both performance counters
//   pc_en, *_en/*_clear PC and pipeline register controls
//   stall_cycles        cycles with pc_en=0
//   flush_count         branch flushes issued
//   mc_busy             FSM waiting on the multi-cycle unit
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  ex_mc_start,
    input  logic                  mc_done,
    input  logic                  dmem_stall,
    input  logic                  perf_clr,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_clear,
    output logic                  id_ex_en,
    output logic                  id_ex_clear,
    output logic                  ex_mem_en,
    output logic                  ex_mem_clear,
    output logic                  mem_wb_en,
    output logic                  mem_wb_clear,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  flush_count,
    output logic                  mc_busy
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   done_latch;
    logic   done_latch_nxt;

    logic mc_release;
    logic mc_stall;
    logic lu;
    logic rs1_hit;
    logic rs2_hit;

    // Mutually exclusive rule selects, highest priority first.
    logic sel_rst;
    logic sel_dmem;
    logic sel_mc;
    logic sel_br;
    logic sel_lu;

    // A result counts once it has arrived (now or earlier while memory
    // was stalling) and memory lets the pipe move this cycle.
    assign mc_release = (mc_done | done_latch) & ~dmem_stall;

    assign mc_stall = ((state == RUN) & ex_mc_start)
                    | ((state == MC_WAIT) & ~mc_release);

    assign rs1_hit = id_rs1_used & (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_used & (id_rs2 == ex_rd);

    // x0 never carries a real dependency.
    assign lu = ex_mem_read & (ex_rd != '0) & (rs1_hit | rs2_hit);

    assign sel_rst  = rst;
    assign sel_dmem = ~rst & dmem_stall;
    assign sel_mc   = ~rst & ~dmem_stall & mc_stall;
    assign sel_br   = ~rst & ~dmem_stall & ~mc_stall & ex_branch_taken;
    assign sel_lu   = ~rst & ~dmem_stall & ~mc_stall & ~ex_branch_taken
                    & lu;

    assign mc_busy = (state == MC_WAIT);

    // ---------------- control outputs ----------------
    // Bubbles and flushes are always en=1, clear=1 because the
    // pipeline registers only honour clear while enabled.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_clear  = 1'b0;
        id_ex_en     = 1'b1;
        id_ex_clear  = 1'b0;
        ex_mem_en    = 1'b1;
        ex_mem_clear = 1'b0;
        mem_wb_en    = 1'b1;
        mem_wb_clear = 1'b0;
        unique case (1'b1)
            sel_rst: begin
                pc_en        = 1'b0;
                if_id_clear  = 1'b1;
                id_ex_clear  = 1'b1;
                ex_mem_clear = 1'b1;
                mem_wb_clear = 1'b1;
            end
            sel_dmem: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_en    = 1'b0;
                mem_wb_clear = 1'b1;
            end
            sel_mc: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_clear = 1'b1;
            end
            sel_br: begin
                if_id_clear  = 1'b1;
                id_ex_clear  = 1'b1;
            end
            sel_lu: begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_clear  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ---------------- multi-cycle FSM ----------------
    always_comb begin
        state_nxt      = state;
        done_latch_nxt = done_latch;
        unique case (state)
            RUN: begin
                // A stray mc_done here is ignored.
                done_latch_nxt = 1'b0;
                if (ex_mc_start) begin
                    state_nxt = MC_WAIT;
                end
            end
            MC_WAIT: begin
                if (mc_release) begin
                    state_nxt      = RUN;
                    done_latch_nxt = 1'b0;
                end else if (mc_done & dmem_stall) begin
                    done_latch_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt      = RUN;
                done_latch_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            done_latch <= 1'b0;
        end else begin
            state      <= state_nxt;
            done_latch <= done_latch_nxt;
        end
    end

    // ---------------- performance counters ----------------
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = ~pc_en & ~(&stall_cycles);
    assign flush_inc = sel_br & ~(&flush_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (perf_clr) begin
                stall_cycles <= '0;
            end else if (stall_inc) begin
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            end
            if (perf_clr) begin
                flush_count <= '0;
            end else if (flush_inc) begin
                flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
